// File: rtl/regs_wb_ctrl.sv
// rtl/regs_wb_ctrl.sv - register-file write-back arbiter with pending-write scoreboard
//
// Shares the single register-file write port between the single-cycle EX
// result and two long-latency requesters (LSU, divider). EX always wins; LSU
// and divider alternate round-robin. If a long-latency request is denied for
// STARVE_LIMIT consecutive cycles, EX is stalled until that request is granted.
// A 32-entry scoreboard marks destinations of issued long-latency ops so ID
// can hold instructions whose sources are still in flight.
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   exFlagIn/exAddrIn/exDataIn      EX write request (never back-pressured)
//   lsuValidIn/lsuAddrIn/lsuDataIn  LSU write request, held until accepted
//   lsuReadyOut                     LSU request accepted this cycle
//   divValidIn/divAddrIn/divDataIn  divider write request, held until accepted
//   divReadyOut                     divider request accepted this cycle
//   issueFlagIn/issueAddrIn         ID issues a long-latency op to this destination
//   rAddr1In/rAddr2In               ID source addresses
//   busy1Out/busy2Out               source has a pending long-latency write
//   exStallOut                      pipeline must hold exFlagIn low while set
//   wFlagOut/wAddrOut/wDataOut      registered register-file write port

module regs_wb_ctrl #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exFlagIn,
    input  logic [4:0]  exAddrIn,
    input  logic [31:0] exDataIn,
    input  logic        lsuValidIn,
    input  logic [4:0]  lsuAddrIn,
    input  logic [31:0] lsuDataIn,
    output logic        lsuReadyOut,
    input  logic        divValidIn,
    input  logic [4:0]  divAddrIn,
    input  logic [31:0] divDataIn,
    output logic        divReadyOut,
    input  logic        issueFlagIn,
    input  logic [4:0]  issueAddrIn,
    input  logic [4:0]  rAddr1In,
    input  logic [4:0]  rAddr2In,
    output logic        busy1Out,
    output logic        busy2Out,
    output logic        exStallOut,
    output logic        wFlagOut,
    output logic [4:0]  wAddrOut,
    output logic [31:0] wDataOut
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        PTR_LSU = 1'b0,
        PTR_DIV = 1'b1
    } ptr_t;

    ptr_t        ptr;
    logic [31:0] sb;
    logic [3:0]  starve_cnt;

    logic        lsu_win;
    logic        div_win;
    logic        lsu_grant;
    logic        div_grant;
    logic        ll_grant;
    logic        any_grant;
    logic [4:0]  g_addr;
    logic [31:0] g_data;
    logic [31:0] sb_next;
    logic [3:0]  cnt_next;
    logic        stall_next;

    // Round-robin only decides a tie; a lone valid request always wins.
    assign lsu_win = lsuValidIn & (~divValidIn | (ptr == PTR_LSU));
    assign div_win = divValidIn & (~lsuValidIn | (ptr == PTR_DIV));

    // Readies are gated by reset so a requester never sees an accept while the
    // controller is being cleared.
    assign lsu_grant = rst & ~exFlagIn & lsu_win;
    assign div_grant = rst & ~exFlagIn & div_win;
    assign ll_grant  = lsu_grant | div_grant;
    assign any_grant = exFlagIn | ll_grant;

    assign lsuReadyOut = lsu_grant;
    assign divReadyOut = div_grant;

    always_comb begin
        g_addr = exAddrIn;
        g_data = exDataIn;
        if (lsu_grant) begin
            g_addr = lsuAddrIn;
            g_data = lsuDataIn;
        end else if (div_grant) begin
            g_addr = divAddrIn;
            g_data = divDataIn;
        end
    end

    // Clear first, then set, so an issue to the address being written back
    // in the same cycle keeps the entry pending.
    always_comb begin
        sb_next = sb;
        if (ll_grant) begin
            sb_next[g_addr] = 1'b0;
        end
        if (issueFlagIn) begin
            sb_next[issueAddrIn] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = starve_cnt;
        if (ll_grant) begin
            cnt_next = 4'd0;
        end else if ((lsuValidIn | divValidIn) && (starve_cnt != LIMIT)) begin
            cnt_next = starve_cnt + 4'd1;
        end
    end

    // Counter only returns to zero on a long-latency grant, so the stall holds
    // from saturation until the starved unit is served.
    always_comb begin
        stall_next = exStallOut;
        if (ll_grant) begin
            stall_next = 1'b0;
        end else if (cnt_next == LIMIT) begin
            stall_next = 1'b1;
        end
    end

    assign busy1Out = sb[rAddr1In];
    assign busy2Out = sb[rAddr2In];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= PTR_LSU;
            sb         <= '0;
            starve_cnt <= '0;
            exStallOut <= 1'b0;
            wFlagOut   <= 1'b0;
            wAddrOut   <= '0;
            wDataOut   <= '0;
        end else begin
            sb         <= sb_next;
            starve_cnt <= cnt_next;
            exStallOut <= stall_next;
            if (ll_grant) begin
                ptr <= (ptr == PTR_LSU) ? PTR_DIV : PTR_LSU;
            end
            // Writes to x0 are accepted but never reach the register file.
            wFlagOut <= any_grant && (g_addr != 5'd0);
            if (any_grant && (g_addr != 5'd0)) begin
                wAddrOut <= g_addr;
                wDataOut <= g_data;
            end
        end
    end

endmodule
